// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU: binary32 field layout, canonical
// special encodings and the divider control states.
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;
    localparam int MANT_W = FRAC_W + 1;
    localparam int Q_W    = 26;

    localparam logic [4:0]  DIV_LAST = 5'd25;
    localparam logic [4:0]  DIV_END  = 5'd26;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV   = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } div_state_e;

    function automatic logic [31:0] signed_inf(input logic sign);
        return POS_INF | {sign, 31'd0};
    endfunction

    function automatic logic [31:0] signed_zero(input logic sign);
        return {sign, 31'd0};
    endfunction

endpackage

// File: rtl/fpu_mant_divider.sv
// Iterative restoring divider for 24-bit significands: one quotient bit per
// clock, 26 bits total (weights 2^0 .. 2^-25), starting on the cycle after load.
module fpu_mant_divider
    import fpu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [MANT_W-1:0] ma_i,
    input  logic [MANT_W-1:0] mb_i,
    output logic              cnt_done_o,
    output logic [Q_W-1:0]    q_o,
    output logic              rem_nonzero_o
);

    logic [MANT_W:0]   rem_q, rem_d, rem_sub_s;
    logic [MANT_W-1:0] mb_q;
    logic [Q_W-1:0]    q_q, q_d;
    logic [4:0]        cnt_q;
    logic              ge_s;

    // One restoring step: trial subtract, keep on success, then shift left
    always_comb begin
        ge_s      = (rem_q >= {1'b0, mb_q});
        rem_sub_s = ge_s ? (rem_q - {1'b0, mb_q}) : rem_q;
        rem_d     = rem_sub_s << 1;
        q_d       = {q_q[Q_W-2:0], ge_s};
    end

    // Iteration state; the counter parks at DIV_END when no division is running
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q <= '0;
            mb_q  <= '0;
            q_q   <= '0;
            cnt_q <= DIV_END;
        end else if (load_i) begin
            rem_q <= {1'b0, ma_i};
            mb_q  <= mb_i;
            q_q   <= '0;
            cnt_q <= 5'd0;
        end else if (cnt_q != DIV_END) begin
            rem_q <= rem_d;
            q_q   <= q_d;
            cnt_q <= cnt_q + 5'd1;
        end
    end

    // cnt_done_o flags the cycle whose closing edge produces the final bit
    assign cnt_done_o    = (cnt_q == DIV_LAST);
    assign q_o           = q_q;
    assign rem_nonzero_o = (rem_q != '0);

endmodule

// File: rtl/fpu_division_unit.sv
// Sequential binary32 divider with start/done handshake and a fixed 28-edge
// latency for every operand class; subnormals flush to zero on input and output.
module fpu_division_unit
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        done,
    output logic        busy
);

    div_state_e state_q, state_d;

    fp32_t             fa_s, fb_s;
    logic              a_zero_s, a_inf_s, a_nan_s, b_zero_s, b_inf_s, b_nan_s;
    logic              sign_s, accept_s, spec_hit_s;
    logic [31:0]       spec_val_s;
    logic signed [9:0] exp_start_s;

    logic              sign_q, special_q, done_q, busy_q;
    logic [31:0]       special_val_q, result_q;
    logic signed [9:0] exp_q;

    logic              cnt_done_s, rem_nz_s;
    logic [Q_W-1:0]    q_s;

    logic [FRAC_W-1:0] mant_s, frac_s;
    logic [MANT_W-1:0] mant_rnd_s;
    logic              guard_s, sticky_s, round_up_s;
    logic signed [9:0] exp_n_s, exp_r_s;
    logic [31:0]       rounded_s, final_s;

    assign fa_s     = a;
    assign fb_s     = b;
    assign accept_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Operand classification; exponent 0 counts as zero so subnormals flush
    always_comb begin
        a_zero_s    = (fa_s.exp == 8'd0);
        b_zero_s    = (fb_s.exp == 8'd0);
        a_inf_s     = (fa_s.exp == 8'hFF) && (fa_s.frac == 23'd0);
        b_inf_s     = (fb_s.exp == 8'hFF) && (fb_s.frac == 23'd0);
        a_nan_s     = (fa_s.exp == 8'hFF) && (fa_s.frac != 23'd0);
        b_nan_s     = (fb_s.exp == 8'hFF) && (fb_s.frac != 23'd0);
        sign_s      = fa_s.sign ^ fb_s.sign;
        exp_start_s = $signed({2'b00, fa_s.exp}) - $signed({2'b00, fb_s.exp}) + 10'sd127;
    end

    // Special-case priority: NaN, invalid, infinity, then zero
    always_comb begin
        spec_hit_s = 1'b1;
        spec_val_s = QNAN;
        if (a_nan_s || b_nan_s) begin
            spec_val_s = QNAN;
        end else if ((a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
            spec_val_s = QNAN;
        end else if (a_inf_s || b_zero_s) begin
            spec_val_s = signed_inf(sign_s);
        end else if (a_zero_s || b_inf_s) begin
            spec_val_s = signed_zero(sign_s);
        end else begin
            spec_hit_s = 1'b0;
            spec_val_s = 32'd0;
        end
    end

    fpu_mant_divider u_mant_div (
        .clk_i         (clk),
        .rst_i         (rst),
        .load_i        (accept_s),
        .ma_i          ({1'b1, fa_s.frac}),
        .mb_i          ({1'b1, fb_s.frac}),
        .cnt_done_o    (cnt_done_s),
        .q_o           (q_s),
        .rem_nonzero_o (rem_nz_s)
    );

    // Normalise the quotient (in [0.5, 2)), round to nearest even, range check
    always_comb begin
        if (q_s[25]) begin
            exp_n_s  = exp_q;
            mant_s   = q_s[24:2];
            guard_s  = q_s[1];
            sticky_s = q_s[0] | rem_nz_s;
        end else begin
            exp_n_s  = exp_q - 10'sd1;
            mant_s   = q_s[23:1];
            guard_s  = q_s[0];
            sticky_s = rem_nz_s;
        end
        round_up_s = guard_s & (sticky_s | mant_s[0]);
        mant_rnd_s = {1'b0, mant_s} + {23'd0, round_up_s};
        if (mant_rnd_s[23]) begin
            frac_s  = 23'd0;
            exp_r_s = exp_n_s + 10'sd1;
        end else begin
            frac_s  = mant_rnd_s[22:0];
            exp_r_s = exp_n_s;
        end
        if (exp_r_s >= 10'sd255) begin
            rounded_s = signed_inf(sign_q);
        end else if (exp_r_s <= 10'sd0) begin
            rounded_s = signed_zero(sign_q);
        end else begin
            rounded_s = {sign_q, exp_r_s[7:0], frac_s};
        end
        final_s = special_q ? special_val_q : rounded_s;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = start ? ST_DIV : ST_IDLE;
            ST_DIV:   state_d = cnt_done_s ? ST_ROUND : ST_DIV;
            ST_ROUND: state_d = ST_DONE;
            ST_DONE:  state_d = start ? ST_DIV : ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture on accept, result/handshake update on leaving ROUND
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q        <= 1'b0;
            exp_q         <= 10'sd0;
            special_q     <= 1'b0;
            special_val_q <= 32'd0;
            result_q      <= 32'd0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else if (accept_s) begin
            sign_q        <= sign_s;
            exp_q         <= exp_start_s;
            special_q     <= spec_hit_s;
            special_val_q <= spec_val_s;
            done_q        <= 1'b0;
            busy_q        <= 1'b1;
        end else if (state_q == ST_ROUND) begin
            result_q      <= final_s;
            done_q        <= 1'b1;
            busy_q        <= 1'b0;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_fpu_division_unit.sv
// Directed and randomised checks of fpu_division_unit against an integer
// reference model of binary32 division (flush-to-zero, round-to-nearest-even).
module tb_fpu_division_unit;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] a, b, result;
    logic        done, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fpu_division_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Quotient taken in one shot by integer division of scaled significands
    function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        logic s;
        int ex, ey, e;
        logic [22:0] fx, fy;
        bit xn, xi, xz, yn, yi, yz, g, st;
        longint unsigned num, den, qf, rf, keep;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        fx = x[22:0];
        fy = y[22:0];
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (fx == 23'd0);
        yi = (ey == 255) && (fy == 23'd0);
        xn = (ex == 255) && (fx != 23'd0);
        yn = (ey == 255) && (fy != 23'd0);
        if (xn || yn) return 32'h7FC00000;
        if ((xz && yz) || (xi && yi)) return 32'h7FC00000;
        if (xi || yz) return {s, 8'hFF, 23'd0};
        if (xz || yi) return {s, 31'd0};
        num = (64'h800000 | 64'(fx)) << 25;
        den = 64'h800000 | 64'(fy);
        qf  = num / den;
        rf  = num % den;
        e   = ex - ey + 127;
        if (qf >= (64'd1 << 25)) begin
            keep = qf >> 2;
            g    = ((qf >> 1) & 64'd1) != 64'd0;
            st   = ((qf & 64'd1) != 64'd0) || (rf != 64'd0);
        end else begin
            e    = e - 1;
            keep = qf >> 1;
            g    = (qf & 64'd1) != 64'd0;
            st   = (rf != 64'd0);
        end
        if (g && (st || ((keep & 64'd1) != 64'd0))) keep = keep + 64'd1;
        if (keep >= (64'd1 << 24)) begin
            keep = keep >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), 23'(keep & 64'h7FFFFF)};
    endfunction

    function automatic logic [31:0] rand_operand();
        int mode;
        logic [31:0] pick;
        mode = int'($urandom_range(0, 9));
        if (mode == 0) begin
            case ($urandom_range(0, 5))
                0: pick = 32'h00000000;
                1: pick = 32'h80000000;
                2: pick = 32'h7F800000;
                3: pick = 32'hFF800000;
                4: pick = 32'h7FC00001;
                default: pick = 32'h00000123;
            endcase
        end else if (mode == 1) begin
            pick = $urandom;
        end else begin
            pick = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
        end
        return pick;
    endfunction

    // Launch one division, optionally poke a second start at edge poke_edge
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] expv,
                          input string tag, input int poke_edge,
                          input logic [31:0] pa, input logic [31:0] pb);
        int lat;
        logic busy_ok;
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        lat = 0;
        busy_ok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) start = 1'b0;
            if (poke_edge > 0 && n == poke_edge - 1) begin
                start = 1'b1;
                a = pa;
                b = pb;
            end
            if (poke_edge > 0 && n == poke_edge) start = 1'b0;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        check({tag, " latency"}, 32'(lat), 32'd28);
        check({tag, " busy during op"}, {31'd0, busy_ok}, 32'd1);
        check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
        check({tag, " result"}, result, expv);
    endtask

    initial begin
        logic [31:0] x, y;
        rst = 1'b1;
        start = 1'b0;
        a = 32'd0;
        b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset result", result, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'h40C00000, 32'h40000000, 32'h40400000, "6/2", 0, 32'd0, 32'd0);
        run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "1/3", 0, 32'd0, 32'd0);
        run_op(32'hC0000000, 32'h3F800000, 32'hC0000000, "-2/1", 0, 32'd0, 32'd0);
        run_op(32'h3F800000, 32'h00000000, 32'h7F800000, "1/0", 0, 32'd0, 32'd0);
        run_op(32'hBF800000, 32'h00000000, 32'hFF800000, "-1/0", 0, 32'd0, 32'd0);
        run_op(32'h00000000, 32'h00000000, 32'h7FC00000, "0/0", 0, 32'd0, 32'd0);
        run_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, "inf/inf", 0, 32'd0, 32'd0);
        run_op(32'h3F800000, 32'h7F800000, 32'h00000000, "1/inf", 0, 32'd0, 32'd0);
        run_op(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, "overflow", 0, 32'd0, 32'd0);
        run_op(32'h00800000, 32'h40000000, 32'h00000000, "underflow", 0, 32'd0, 32'd0);
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, "ignored start", 10,
               32'h3F800000, 32'h40400000);

        @(negedge clk);
        a = 32'h12345678;
        b = 32'h3F800000;
        repeat (5) @(posedge clk);
        #1;
        check("hold result", result, 32'h40400000);
        check("hold done", {31'd0, done}, 32'd1);

        for (int i = 0; i < 40; i++) begin
            x = rand_operand();
            y = rand_operand();
            run_op(x, y, ref_div(x, y), "random", 0, 32'd0, 32'd0);
        end

        // Reset in the middle of a division
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, "pre-reset", 0, 32'd0, 32'd0);
        @(negedge clk);
        a = 32'h40490FDB;
        b = 32'h402DF854;
        start = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("midop reset result", result, 32'd0);
        check("midop reset done", {31'd0, done}, 32'd0);
        check("midop reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'h40490FDB, 32'h402DF854, ref_div(32'h40490FDB, 32'h402DF854),
               "after reset", 0, 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
